regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single 32x32 register-file write port between two writeback sources:
//  A = ALU, B = load unit. Each source has a small queue. Queue heads are granted
//  round-robin, one write per cycle. A busy_vec scoreboard marks registers that have
//  writes queued but not yet committed. Issue logic uses busy_vec to stall dependent reads.
// PARAMETERS
//  DEPTH   2   entries per source queue; power of 2, >=2
//  ADDR_W  5   register address width
//  DATA_W  32  register data width
// PORTS
//  clk       in   1       clock; all state updates on posedge
//  rst_n     in   1       reset, asynchronous, active-low
//  a_valid   in   1       source A write request
//  a_ready   out  1       source A queue can accept
//  a_addr    in   ADDR_W  source A destination register
//  a_data    in   DATA_W  source A write data
//  b_valid   in   1       source B write request
//  b_ready   out  1       source B queue can accept
//  b_addr    in   ADDR_W  source B destination register
//  b_data    in   DATA_W  source B write data
//  rf_we     out  1       register-file write enable
//  rf_waddr  out  ADDR_W  register-file write address
//  rf_wdata  out  DATA_W  register-file write data
//  busy_vec  out  32      bit r = 1 while >=1 accepted write to r is uncommitted
//  idle      out  1       both queues empty
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - Queues emptied; rr pointer set to A; all busy counters cleared.
//   - Outputs: a_ready=b_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, idle=1.
//   - Reset mid-operation discards queued writes. No rf_we while rst_n=0.
//  Accept:
//   - A transfer happens on a posedge with x_valid && x_ready.
//   - x_ready = !full(x). It is independent of x_valid and of the other source.
//   - addr==0 transfers are accepted and dropped: no enqueue, no busy change, no rf_we.
//  Grant:
//   - Evaluated combinationally each cycle from the queue heads.
//   - Neither queue non-empty: rf_we=0; rf_waddr and rf_wdata hold 0.
//   - One queue non-empty: that head is granted.
//   - Both non-empty: the rr pointer source is granted. The rr pointer then flips
//     to the other source on the posedge.
//   - Same-address heads in both queues: A is granted regardless of rr, and rr is
//     unchanged. Issue logic must not create this case; the bench asserts it never occurs.
//   - The granted head drives rf_we=1, rf_waddr, rf_wdata. It pops on the same posedge
//     the register file commits.
//   - Latency: accepted at posedge N -> rf_we in cycle N+1 at the earliest.
//     Throughput: 1 write/cycle total.
//  Full / empty:
//   - A push to a full queue cannot occur (ready=0).
//   - A pop and a push on the same queue in one cycle are both legal. A full queue
//     still shows ready=0 that cycle, with no combinational ready path from the grant.
//   - Pointers wrap modulo DEPTH. Occupancy counter width is $clog2(DEPTH+1).
//  Scoreboard:
//   - Per register r (1..31), counter cnt[r] with width $clog2(2*DEPTH+1).
//   - Two increments are possible per posedge (A and B push to the same r).
//     Decrement by 1 on grant of r. Simultaneous inc and dec apply net.
//   - busy_vec[r] = (cnt[r] != 0). busy_vec[0] = 0 always.
//   - Counter overflow is impossible by construction; the bench asserts it.
// CONFIGURATION
//  WB_ARB_BYPASS_EN defined:
//   - Condition: the queue of source x is empty, x_valid=1, and x would win the grant
//     with both queues considered.
//   - Effect: that request is written in the same cycle (rf_* driven combinationally
//     from a_*/b_*), is not enqueued, and does not change busy_vec. Latency is 0.
//   - Both sources valid with both queues empty: the rr winner bypasses, the loser
//     enqueues, and rr flips.
//  WB_ARB_BYPASS_EN undefined: every request passes through its queue; minimum latency 1.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles -> rf_we=0, busy_vec=0, idle=1, a_ready=b_ready=1.
//  2. A pushes (r5, 0xDEADBEEF) -> next cycle rf_we=1, rf_waddr=5,
//     rf_wdata=0xDEADBEEF; busy_vec[5] is 1 for exactly 1 cycle (0 with WB_ARB_BYPASS_EN).
//  3. Both push every cycle for 8 cycles (A->r1.., B->r9..) -> grants alternate A,B,A,...;
//     ready drops when a queue holds DEPTH=2; all 16 writes commit in per-source order.
//  4. A pushes r3, r3 back-to-back while its head is stalled -> busy_vec[3] stays 1
//     until the second r3 commits; rf_wdata order matches push order.
//  5. A pushes addr 0, data 0x1234 -> no rf_we, busy_vec unchanged, idle stays 1.
//  6. Queue B full (2 entries), assert rst_n=0 mid-cycle -> busy_vec=0 and b_ready=1
//     immediately; no rf_we for the discarded entries after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-source (ALU/load) writeback arbiter for a 32x32 register file, with a per-register busy scoreboard.
// Optional build macro WB_ARB_BYPASS_EN: an empty-queue request that wins arbitration writes in the same cycle.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [31:0]       busy_vec,
    output logic              idle
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = $clog2(2 * DEPTH + 1);
    localparam int unsigned NREG  = 32;
    localparam int unsigned NSRC  = 2;
    localparam logic        SRC_A = 1'b0;

    // Source 0 is A (ALU), source 1 is B (load unit).
    logic [NSRC-1:0]   in_valid;
    logic [ADDR_W-1:0] in_addr   [NSRC];
    logic [DATA_W-1:0] in_data   [NSRC];

    logic [ADDR_W-1:0] q_addr_q  [NSRC][DEPTH];
    logic [DATA_W-1:0] q_data_q  [NSRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q  [NSRC];
    logic [PTR_W-1:0]  wr_ptr_d  [NSRC];
    logic [PTR_W-1:0]  rd_ptr_q  [NSRC];
    logic [PTR_W-1:0]  rd_ptr_d  [NSRC];
    logic [OCC_W-1:0]  occ_q     [NSRC];
    logic [OCC_W-1:0]  occ_d     [NSRC];
    logic              rr_q;
    logic              rr_d;
    logic [CNT_W-1:0]  cnt_q     [NREG];
    logic [CNT_W-1:0]  cnt_d     [NREG];

    logic [NSRC-1:0]   empty;
    logic [NSRC-1:0]   full;
    logic [NSRC-1:0]   ready;
    logic [ADDR_W-1:0] head_addr [NSRC];
    logic [DATA_W-1:0] head_data [NSRC];

    logic [NSRC-1:0]   cand;
    logic [ADDR_W-1:0] cand_addr [NSRC];
    logic [DATA_W-1:0] cand_data [NSRC];
    logic [NSRC-1:0]   gnt;
    logic [NSRC-1:0]   pop;
    logic [NSRC-1:0]   byp;
    logic [NSRC-1:0]   push;
    logic              both;
    logic              same;
    logic              dec_en;
    logic [ADDR_W-1:0] dec_addr;

    assign in_valid   = {b_valid, a_valid};
    assign in_addr[0] = a_addr;
    assign in_addr[1] = b_addr;
    assign in_data[0] = a_data;
    assign in_data[1] = b_data;

    // Ready depends only on stored occupancy, never on this cycle's grant.
    always_comb begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            empty[s]     = (occ_q[s] == '0);
            full[s]      = (occ_q[s] == OCC_W'(DEPTH));
            ready[s]     = !full[s];
            head_addr[s] = q_addr_q[s][rd_ptr_q[s]];
            head_data[s] = q_data_q[s][rd_ptr_q[s]];
        end
    end

    always_comb begin
        for (int unsigned s = 0; s < NSRC; s++) begin
`ifdef WB_ARB_BYPASS_EN
            // An empty queue competes with its live request so the winner can skip the queue.
            cand[s]      = !empty[s] || (rst_n && in_valid[s] && (in_addr[s] != '0));
            cand_addr[s] = empty[s] ? in_addr[s] : head_addr[s];
            cand_data[s] = empty[s] ? in_data[s] : head_data[s];
`else
            cand[s]      = !empty[s];
            cand_addr[s] = head_addr[s];
            cand_data[s] = head_data[s];
`endif
        end
    end

    // Same-address contenders always resolve to A and leave the rr pointer alone.
    always_comb begin
        both   = cand[0] && cand[1];
        same   = both && (cand_addr[0] == cand_addr[1]);
        gnt    = '0;
        gnt[0] = cand[0] && (!cand[1] || same || (rr_q == SRC_A));
        gnt[1] = cand[1] && !gnt[0];
        rr_d   = (both && !same) ? ~rr_q : rr_q;

        pop = '0;
        byp = '0;
        for (int unsigned s = 0; s < NSRC; s++) begin
            pop[s] = gnt[s] && !empty[s];
            byp[s] = gnt[s] && empty[s];
        end

        rf_we    = |gnt;
        rf_waddr = '0;
        rf_wdata = '0;
        if (gnt[0]) begin
            rf_waddr = cand_addr[0];
            rf_wdata = cand_data[0];
        end else if (gnt[1]) begin
            rf_waddr = cand_addr[1];
            rf_wdata = cand_data[1];
        end

        dec_en   = |pop;
        dec_addr = pop[0] ? head_addr[0] : head_addr[1];
    end

    // Writes to r0 complete the handshake but are discarded.
    always_comb begin
        push = '0;
        for (int unsigned s = 0; s < NSRC; s++) begin
            push[s] = in_valid[s] && ready[s] && (in_addr[s] != '0) && !byp[s];
        end
    end

    always_comb begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            wr_ptr_d[s] = push[s] ? wr_ptr_q[s] + PTR_W'(1) : wr_ptr_q[s];
            rd_ptr_d[s] = pop[s]  ? rd_ptr_q[s] + PTR_W'(1) : rd_ptr_q[s];
            occ_d[s]    = occ_q[s];
            if (push[s] && !pop[s]) begin
                occ_d[s] = occ_q[s] + OCC_W'(1);
            end else if (!push[s] && pop[s]) begin
                occ_d[s] = occ_q[s] - OCC_W'(1);
            end
        end
    end

    // Scoreboard: up to two increments and one decrement per register per cycle, applied net.
    always_comb begin
        logic inc_a;
        logic inc_b;
        logic dec;
        inc_a    = 1'b0;
        inc_b    = 1'b0;
        dec      = 1'b0;
        busy_vec = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int unsigned r = 1; r < NREG; r++) begin
            inc_a       = push[0] && (in_addr[0] == ADDR_W'(r));
            inc_b       = push[1] && (in_addr[1] == ADDR_W'(r));
            dec         = dec_en && (dec_addr == ADDR_W'(r));
            cnt_d[r]    = cnt_q[r] + CNT_W'(inc_a) + CNT_W'(inc_b) - CNT_W'(dec);
            busy_vec[r] = (cnt_q[r] != '0);
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                occ_q[s]    <= '0;
            end
            rr_q <= SRC_A;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                occ_q[s]    <= occ_d[s];
            end
            rr_q <= rr_d;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                q_addr_q[s][wr_ptr_q[s]] <= in_addr[s];
                q_data_q[s][wr_ptr_q[s]] <= in_data[s];
            end
        end
    end

    assign a_ready = ready[0];
    assign b_ready = ready[1];
    assign idle    = &empty;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, multi-cycle sequences, and
// randomized traffic compared against a queue-based reference model (honours WB_ARB_BYPASS_EN).
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
`ifdef WB_ARB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, rf_we, idle;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, busy_vec;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec), .idle(idle)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: two FIFOs of pending writes plus a "who goes first" bit.
    typedef struct packed { logic [4:0] addr; logic [31:0] data; } ent_t;
    ent_t mqa[$];
    ent_t mqb[$];
    bit   m_prefer_b;
    int   m_gnt;           // 0 none, 1 A, 2 B
    bit   m_byp, m_contend;
    logic        exp_we, exp_ar, exp_br, exp_idle;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data, exp_busy;

    function automatic void model_reset();
        mqa.delete();
        mqb.delete();
        m_prefer_b = 1'b0;
    endfunction

    function automatic void model_eval();
        bit ca = 0, cb = 0, ba = 0, bb = 0;
        ent_t ea, eb;
        ea = '0;
        eb = '0;
        assert (!(mqa.size() > 0 && mqb.size() > 0 && mqa[0].addr == mqb[0].addr))
            else $error("same-address queue heads in both sources");
        if (mqa.size() > 0) begin ca = 1; ea = mqa[0]; end
        else if (BYPASS && a_valid && a_addr != 0) begin ca = 1; ba = 1; ea.addr = a_addr; ea.data = a_data; end
        if (mqb.size() > 0) begin cb = 1; eb = mqb[0]; end
        else if (BYPASS && b_valid && b_addr != 0) begin cb = 1; bb = 1; eb.addr = b_addr; eb.data = b_data; end
        m_contend = ca && cb && (ea.addr != eb.addr);
        if (ca && cb) m_gnt = m_contend ? (m_prefer_b ? 2 : 1) : 1;
        else if (ca)  m_gnt = 1;
        else if (cb)  m_gnt = 2;
        else          m_gnt = 0;
        m_byp    = (m_gnt == 1 && ba) || (m_gnt == 2 && bb);
        exp_we   = (m_gnt != 0);
        exp_addr = (m_gnt == 1) ? ea.addr : (m_gnt == 2) ? eb.addr : 5'd0;
        exp_data = (m_gnt == 1) ? ea.data : (m_gnt == 2) ? eb.data : 32'd0;
        exp_busy = '0;
        foreach (mqa[i]) exp_busy[mqa[i].addr] = 1'b1;
        foreach (mqb[i]) exp_busy[mqb[i].addr] = 1'b1;
        exp_busy[0] = 1'b0;
        exp_ar   = (mqa.size() < DEPTH);
        exp_br   = (mqb.size() < DEPTH);
        exp_idle = (mqa.size() == 0) && (mqb.size() == 0);
    endfunction

    function automatic void model_commit();
        ent_t e;
        int pend;
        if (m_gnt == 1 && !m_byp) void'(mqa.pop_front());
        if (m_gnt == 2 && !m_byp) void'(mqb.pop_front());
        if (m_contend) m_prefer_b = !m_prefer_b;
        if (a_valid && exp_ar && a_addr != 0 && !(m_gnt == 1 && m_byp)) begin
            e.addr = a_addr; e.data = a_data; mqa.push_back(e);
        end
        if (b_valid && exp_br && b_addr != 0 && !(m_gnt == 2 && m_byp)) begin
            e.addr = b_addr; e.data = b_data; mqb.push_back(e);
        end
        for (int r = 1; r < 32; r++) begin
            pend = 0;
            foreach (mqa[i]) if (mqa[i].addr == r) pend++;
            foreach (mqb[i]) if (mqb[i].addr == r) pend++;
            assert (pend <= 2 * DEPTH) else $error("pending count overflow on r%0d", r);
        end
    endfunction

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        model_eval();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_commit();
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rf_we"},    rf_we,    exp_we);
        chk({tag, ".rf_waddr"}, rf_waddr, exp_addr);
        chk({tag, ".rf_wdata"}, rf_wdata, exp_data);
        chk({tag, ".busy_vec"}, busy_vec, exp_busy);
        chk({tag, ".a_ready"},  a_ready,  exp_ar);
        chk({tag, ".b_ready"},  b_ready,  exp_br);
        chk({tag, ".idle"},     idle,     exp_idle);
    endtask

    typedef struct {
        logic av; logic [4:0] aa; logic [31:0] ad;
        logic bv; logic [4:0] ba; logic [31:0] bd;
        logic we; logic [4:0] wa; logic [31:0] wd;
        logic [31:0] busy; logic ar; logic br; logic idl;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                                logic bv, logic [4:0] ba, logic [31:0] bd,
                                logic we, logic [4:0] wa, logic [31:0] wd,
                                logic [31:0] busy, logic ar, logic br, logic idl);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.we = we; v.wa = wa; v.wd = wd; v.busy = busy; v.ar = ar; v.br = br; v.idl = idl;
        return v;
    endfunction

    function automatic logic [31:0] bits(input int r0, input int r1 = 0, input int r2 = 0);
        logic [31:0] m = '0;
        if (r0 != 0) m[r0] = 1'b1;
        if (r1 != 0) m[r1] = 1'b1;
        if (r2 != 0) m[r2] = 1'b1;
        return m;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, ".rf_we"},    rf_we,    1'b0);
        chk({tag, ".rf_waddr"}, rf_waddr, 5'd0);
        chk({tag, ".rf_wdata"}, rf_wdata, 32'd0);
        chk({tag, ".busy_vec"}, busy_vec, 32'd0);
        chk({tag, ".a_ready"},  a_ready,  1'b1);
        chk({tag, ".b_ready"},  b_ready,  1'b1);
        chk({tag, ".idle"},     idle,     1'b1);
    endtask

    initial begin
        int ai, bi, commits;
        bit acc_a, acc_b;
        logic [4:0] ra, rb;

        // Reset held for three cycles.
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table (expected values for the queued build, rr starting at A).
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,  0, 0, 0,             32'd0,          1, 1, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,  1, 5, 32'hDEADBEEF,  bits(5),        1, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,  0, 0, 0,             32'd0,          1, 1, 1));
        tbl.push_back(mk(1, 0, 32'h1234,     0, 0, 0,  0, 0, 0,             32'd0,          1, 1, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,  0, 0, 0,             32'd0,          1, 1, 1));
        tbl.push_back(mk(1, 3, 32'h33330001, 1, 7, 32'h77770001, 0, 0, 0,   32'd0,          1, 1, 1));
        tbl.push_back(mk(1, 3, 32'h33330002, 0, 0, 0,  1, 3, 32'h33330001,  bits(3, 7),     1, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,  1, 7, 32'h77770001,  bits(3, 7),     1, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,  1, 3, 32'h33330002,  bits(3),        1, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,  0, 0, 0,             32'd0,          1, 1, 1));
        tbl.push_back(mk(1, 1, 32'hA1,       1, 9, 32'hB1,  0, 0, 0,        32'd0,          1, 1, 1));
        tbl.push_back(mk(1, 2, 32'hA2,       1, 10, 32'hB2, 1, 1, 32'hA1,   bits(1, 9),     1, 1, 0));
        tbl.push_back(mk(1, 4, 32'hA3,       1, 11, 32'hB3, 1, 9, 32'hB1,   bits(2, 9, 10), 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,  1, 2, 32'hA2,        bits(2, 4, 10), 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,  1, 10, 32'hB2,       bits(4, 10),    1, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,  1, 4, 32'hA3,        bits(4),        1, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,  0, 0, 0,             32'd0,          1, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd);
            if (BYPASS) begin
                check_model(tag);
            end else begin
                chk({tag, ".rf_we"},    rf_we,    tbl[i].we);
                chk({tag, ".rf_waddr"}, rf_waddr, tbl[i].wa);
                chk({tag, ".rf_wdata"}, rf_wdata, tbl[i].wd);
                chk({tag, ".busy_vec"}, busy_vec, tbl[i].busy);
                chk({tag, ".a_ready"},  a_ready,  tbl[i].ar);
                chk({tag, ".b_ready"},  b_ready,  tbl[i].br);
                chk({tag, ".idle"},     idle,     tbl[i].idl);
            end
            finish_cycle();
        end

        // Both sources stream 8 writes each, holding each request until accepted.
        ai = 0; bi = 0; commits = 0;
        for (int c = 0; c < 40; c++) begin
            if (ai >= 8 && bi >= 8 && mqa.size() == 0 && mqb.size() == 0) break;
            drive(ai < 8, 5'(1 + ai), 32'hA000_0000 + ai, bi < 8, 5'(9 + bi), 32'hB000_0000 + bi);
            check_model("stream");
            if (rf_we === 1'b1) commits++;
            acc_a = a_valid && exp_ar;
            acc_b = b_valid && exp_br;
            finish_cycle();
            if (acc_a) ai++;
            if (acc_b) bi++;
        end
        chk("stream.commits", commits, 16);

        // Fill B, then reset asynchronously in the middle of a cycle.
        for (int c = 0; c < 6 && mqb.size() < DEPTH; c++) begin
            drive(1'b1, 5'(1 + c), 32'hC000_0000 + c, 1'b1, 5'(20 + c), 32'hD000_0000 + c);
            check_model("fill");
            finish_cycle();
        end
        #2;
        chk("midrst.pre_b_ready", b_ready, 1'b0);
        rst_n = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h5555;
        b_valid = 1'b0;
        #1;
        check_reset_state("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("midrst.hold_rf_we", rf_we, 1'b0);
        @(negedge clk);
        a_valid = 1'b0; a_addr = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0, 0);
            check_model("postrst");
            finish_cycle();
        end

        // Random traffic; A and B use disjoint register ranges, with occasional r0 writes.
        for (int c = 0; c < 1500; c++) begin
            ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
            rb = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
            drive($urandom_range(0, 99) < 65, ra, $urandom,
                  $urandom_range(0, 99) < 65, rb, $urandom);
            check_model("rand");
            finish_cycle();
        end
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 0, 0, 0);
            check_model("drain");
            finish_cycle();
        end
        #1;
        chk("final.idle", idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
